// File: rtl/mem_access_unit.sv
// Memory port for a multicycle CPU: runs one fetch/load/store per request on a
// single-port, wait-state memory and reports done / misalign / timeout.
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        IorD,
   input  logic        MemWrite,
   input  logic [1:0]  lsop,
   input  logic        dmEXTop,
   input  logic [31:0] pc,
   input  logic [31:0] alu_out,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   output logic [31:0] ir,
   output logic [31:0] mdr,
   output logic        busy,
   output logic        done,
   output logic        misalign_err,
   output logic        timeout_err
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
   state_t state, state_n;

   logic [31:0]   req_addr;
   logic [1:0]    req_size;
   logic          req_misalign;
   logic [3:0]    req_be;
   logic [31:0]   req_wdata;
   logic          start, finish, abort, misalign;
   logic          lat_data, lat_write, lat_zext;
   logic [1:0]    lat_size, lat_off;
   logic [CW-1:0] wait_cnt;
   logic [7:0]    byte_lane;
   logic [15:0]   half_lane;
   logic [31:0]   load_ext;

   // Fetches are always aligned words; lsop=11 behaves as a word.
   always_comb begin
      req_addr     = IorD ? alu_out : pc;
      req_size     = (IorD && lsop != 2'b11) ? lsop : 2'b00;
      req_misalign = IorD && ((req_size == 2'b00 && req_addr[1:0] != 2'b00) ||
                              (req_size == 2'b01 && req_addr[0]));
      case (req_size)
         2'b10: begin
            req_be    = 4'b0001 << req_addr[1:0];
            req_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{wdata[15:0]}};
         end
         default: begin
            req_be    = 4'b1111;
            req_wdata = wdata;
         end
      endcase
   end

   always_comb begin
      byte_lane = mem_rdata[{lat_off, 3'b000} +: 8];
      half_lane = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (lat_size)
         2'b10:   load_ext = lat_zext ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         2'b01:   load_ext = lat_zext ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // A ready on the last permitted cycle still completes the access.
   always_comb begin
      state_n  = state;
      start    = 1'b0;
      misalign = 1'b0;
      finish   = 1'b0;
      abort    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (req_misalign) begin
                  misalign = 1'b1;
               end else begin
                  start   = 1'b1;
                  state_n = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (mem_ready) begin
               finish  = 1'b1;
               state_n = IDLE;
            end else if (wait_cnt == CNT_LAST) begin
               abort   = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state == ACCESS);

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_be       <= 4'd0;
         mem_wdata    <= 32'd0;
         ir           <= 32'd0;
         mdr          <= 32'd0;
         done         <= 1'b0;
         misalign_err <= 1'b0;
         timeout_err  <= 1'b0;
         lat_data     <= 1'b0;
         lat_write    <= 1'b0;
         lat_zext     <= 1'b0;
         lat_size     <= 2'd0;
         lat_off      <= 2'd0;
         wait_cnt     <= '0;
      end else begin
         done         <= finish | abort | misalign;
         misalign_err <= misalign;
         timeout_err  <= abort;
         if (start) begin
            mem_en    <= 1'b1;
            mem_we    <= IorD & MemWrite;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= req_be;
            mem_wdata <= req_wdata;
            lat_data  <= IorD;
            lat_write <= IorD & MemWrite;
            lat_size  <= req_size;
            lat_off   <= req_addr[1:0];
            lat_zext  <= dmEXTop;
            wait_cnt  <= '0;
         end else if (finish || abort) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 4'd0;
         end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
         if (finish) begin
            if (!lat_data)      ir  <= mem_rdata;
            else if (!lat_write) mdr <= load_ext;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: driver pushes expected bus cycles and
// completions into queues, a negedge monitor pops and compares them.
module tb_mem_access_unit;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst, req, IorD, MemWrite, dmEXTop, mem_ready;
   logic [1:0]  lsop;
   logic [31:0] pc, alu_out, wdata, mem_rdata;
   logic        mem_en, mem_we, busy, done, misalign_err, timeout_err;
   logic [31:0] mem_addr, mem_wdata, ir, mdr;
   logic [3:0]  mem_be;

   int errors = 0;
   int checks = 0;

   // {busy_cycles[7:0], misalign, timeout, ir[31:0], mdr[31:0]}
   logic [73:0] exp_q[$];
   // {we, be[3:0], addr[31:0], wdata[31:0]}
   logic [68:0] bus_q[$];
   logic [31:0] m_ir = 32'd0;
   logic [31:0] m_mdr = 32'd0;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .IorD(IorD), .MemWrite(MemWrite),
      .lsop(lsop), .dmEXTop(dmEXTop), .pc(pc), .alu_out(alu_out), .wdata(wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .ir(ir), .mdr(mdr),
      .busy(busy), .done(done), .misalign_err(misalign_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: sizes 0=word 1=half 2=byte, computed with plain arithmetic.
   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
      if (sz == 2'd2) return 4'(1 << off);
      if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd2) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] sz,
                                              input logic [1:0] off, input logic zext);
      int unsigned v, bits;
      if (sz == 2'd2) begin
         bits = 8;
         v = (d >> (8 * off)) & 32'hFF;
      end else if (sz == 2'd1) begin
         bits = 16;
         v = (d >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
      end else begin
         return d;
      end
      if (!zext && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
      return v;
   endfunction

   task automatic scramble();
      IorD = 1'($urandom); MemWrite = 1'($urandom); lsop = 2'($urandom);
      dmEXTop = 1'($urandom); pc = $urandom; alu_out = $urandom; wdata = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         req = 1'b0; mem_ready = 1'($urandom); mem_rdata = $urandom;
         @(posedge clk); @(negedge clk);
      end
      mem_ready = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge of the cycle where done is expected.
   task automatic do_txn(input logic f_iord, input logic f_we, input logic [1:0] f_lsop,
                         input logic f_zext, input logic [31:0] f_pc, input logic [31:0] f_alu,
                         input logic [31:0] f_wd, input logic [31:0] f_rdata,
                         input int waits, input bit busy_req);
      logic [1:0]  sz, off;
      logic [31:0] a;
      logic        mis, tmo;
      int          acc;
      sz  = (!f_iord || f_lsop == 2'b11) ? 2'd0 : f_lsop;
      a   = f_iord ? f_alu : f_pc;
      off = a[1:0];
      mis = f_iord && ((sz == 2'd0 && off != 0) || (sz == 2'd1 && (off % 2) != 0));
      tmo = !mis && waits >= TO;
      acc = mis ? 0 : (tmo ? TO : waits + 1);
      if (!mis) bus_q.push_back({f_iord & f_we, model_be(sz, off), a & 32'hFFFF_FFFC, model_wd(sz, f_wd)});
      if (!mis && !tmo) begin
         if (!f_iord)   m_ir  = f_rdata;
         else if (!f_we) m_mdr = model_load(f_rdata, sz, off, f_zext);
      end
      exp_q.push_back({8'(acc), mis, tmo, m_ir, m_mdr});

      req = 1'b1; IorD = f_iord; MemWrite = f_we; lsop = f_lsop; dmEXTop = f_zext;
      pc = f_pc; alu_out = f_alu; wdata = f_wd; mem_ready = 1'b0; mem_rdata = $urandom;
      @(posedge clk); @(negedge clk);
      req = 1'b0;
      scramble();
      for (int k = 0; k < acc; k++) begin
         req = busy_req && (k == 0);
         mem_ready = !tmo && (k == waits);
         mem_rdata = mem_ready ? f_rdata : $urandom;
         @(posedge clk); @(negedge clk);
         req = 1'b0; mem_ready = 1'b0; mem_rdata = $urandom;
      end
   endtask

   // Monitor: compares each bus cycle start and each completion against the queues.
   int busy_cnt = 0;
   logic prev_en = 1'b0;
   always @(negedge clk) begin
      logic [68:0] b;
      logic [73:0] e;
      if (busy === 1'b1) busy_cnt++;
      if (mem_en === 1'b1 && prev_en !== 1'b1) begin
         if (bus_q.size() == 0) begin
            chk("unexpected_mem_en", 64'(mem_en), 64'd0);
         end else begin
            b = bus_q.pop_front();
            chk("mem_we", 64'(mem_we), 64'(b[68]));
            chk("mem_be", 64'(mem_be), 64'(b[67:64]));
            chk("mem_addr", 64'(mem_addr), 64'(b[63:32]));
            chk("mem_wdata", 64'(mem_wdata), 64'(b[31:0]));
         end
      end
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("busy_cycles", 64'(busy_cnt), 64'(e[73:66]));
            chk("misalign_err", 64'(misalign_err), 64'(e[65]));
            chk("timeout_err", 64'(timeout_err), 64'(e[64]));
            chk("ir", 64'(ir), 64'(e[63:32]));
            chk("mdr", 64'(mdr), 64'(e[31:0]));
            chk("done_bus_idle", 64'({mem_en, mem_we, mem_be, busy}), 64'd0);
         end
         busy_cnt = 0;
      end else begin
         if (misalign_err === 1'b1 || timeout_err === 1'b1)
            chk("err_without_done", 64'({misalign_err, timeout_err}), 64'd0);
         if (busy !== 1'b1) busy_cnt = 0;
      end
      prev_en = mem_en;
   end

   initial begin
      rst = 1'b1; req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
      IorD = 1'b0; MemWrite = 1'b0; lsop = 2'd0; dmEXTop = 1'b0;
      pc = 32'd0; alu_out = 32'd0; wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_outputs", 64'({mem_en, mem_we, mem_be, busy, done, misalign_err, timeout_err}), 64'd0);
      chk("reset_ir", 64'(ir), 64'd0);
      chk("reset_mdr", 64'(mdr), 64'd0);
      chk("reset_addr_wdata", {mem_addr, mem_wdata}, 64'd0);

      do_txn(0, 0, 2'b00, 0, 32'h0040_0004, 32'h1, 32'h5, 32'h8C22_0008, 0, 0);
      do_txn(1, 0, 2'b10, 0, 32'h0, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 3, 0);
      do_txn(1, 0, 2'b10, 1, 32'h0, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 3, 0);
      do_txn(1, 1, 2'b01, 0, 32'h0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 0);
      do_txn(1, 0, 2'b00, 0, 32'h0, 32'h0000_3001, 32'h0, 32'hDEAD_BEEF, 0, 0);
      do_txn(1, 0, 2'b00, 0, 32'h0, 32'h0000_4000, 32'h0, 32'h1111_2222, TO + 3, 0);
      do_txn(0, 0, 2'b00, 0, 32'h0000_4004, 32'h0, 32'h0, 32'h3333_4444, TO + 3, 0);
      do_txn(1, 0, 2'b01, 0, 32'h0, 32'h0000_4006, 32'h0, 32'h8001_7FFF, TO - 1, 0);
      do_txn(1, 0, 2'b11, 0, 32'h0, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 1, 0);
      do_txn(1, 0, 2'b00, 0, 32'h0, 32'h0000_5008, 32'h0, 32'h0BAD_CAFE, 2, 1);
      idle(2);

      for (int n = 0; n < 250; n++) begin
         int w;
         logic [31:0] ad;
         w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
         ad = $urandom;
         if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
         do_txn($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 1'($urandom),
                $urandom, ad, $urandom, $urandom, w, $urandom_range(0, 3) == 0);
         idle($urandom_range(0, 2));
      end
      idle(2);

      // Reset during the second wait cycle of a load.
      bus_q.push_back({1'b0, 4'b1000, 32'h0000_6000, 32'h0});
      req = 1'b1; IorD = 1'b1; MemWrite = 1'b0; lsop = 2'b10; dmEXTop = 1'b0;
      alu_out = 32'h0000_6003; wdata = 32'h0; mem_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      req = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      m_ir = 32'd0; m_mdr = 32'd0;
      chk("midrst_outputs", 64'({mem_en, mem_we, mem_be, busy, done, misalign_err, timeout_err}), 64'd0);
      chk("midrst_ir_mdr", {ir, mdr}, 64'd0);
      chk("midrst_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      mem_ready = 1'b0;
      chk("ready_after_rst_ignored", {ir, mdr}, 64'd0);
      chk("no_done_after_rst", 64'({done, busy, mem_en}), 64'd0);

      do_txn(1, 0, 2'b01, 1, 32'h0, 32'h0000_7002, 32'h0, 32'hFEDC_0000, 1, 0);
      idle(3);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multicycle-CPU memory port sitting directly downstream of the main control FSM.
- Takes the controller's access request (IorD, MemWrite, lsop, dmEXTop) plus PC / ALUOut / B-register values and runs a single-port, wait-state-tolerant memory transaction.
- Generates byte enables and lane-replicated write data.
- Captures instruction words into IR and extended load data into MDR, and reports done / misalign / timeout back to the controller.

Parameters:
TIMEOUT, 16, max cycles in ACCESS waiting for mem_ready before abort (>=1)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
req  input  1  one-cycle access request from controller
IorD  input  1  0 = instruction fetch at pc, 1 = data access at alu_out
MemWrite  input  1  data store when IorD=1
lsop  input  2  size: 00 word, 01 half, 10 byte, 11 treated as word
dmEXTop  input  1  load extension: 0 sign, 1 zero
pc  input  32  fetch address
alu_out  input  32  data address
wdata  input  32  store data (B register), value in low bits
mem_rdata  input  32  memory read data, valid when mem_ready=1
mem_ready  input  1  memory completion strobe
mem_en  output  1  memory transaction active
mem_we  output  1  memory write strobe
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
mem_wdata  output  32  lane-replicated store data
ir  output  32  instruction register
mdr  output  32  memory data register (extended load result)
busy  output  1  1 while not IDLE
done  output  1  one-cycle completion pulse
misalign_err  output  1  one-cycle pulse with done on misaligned data access
timeout_err  output  1  one-cycle pulse with done on timeout

Behaviour:
- Reset (rst=1 at clk edge):
  - Outputs: all zero (ir, mdr, mem_*, busy, done, errors); state IDLE; timeout counter 0.
  - Applies mid-transaction: mem_en drops the next cycle, no capture.
- FSM states: IDLE, ACCESS.
- IDLE, req=1: latch IorD, MemWrite, lsop, dmEXTop, address (pc if IorD=0, else alu_out) and wdata.
- Fetch (IorD=0):
  - Always word, read-only; MemWrite, lsop and dmEXTop are ignored.
  - pc[1:0] is ignored and no misalign check is made.
- Misalign check (IorD=1 only): half with a[0]=1, or word with a[1:0]!=0.
  - No memory access, stays IDLE.
  - Next cycle: done=1, misalign_err=1; ir and mdr unchanged.
- Otherwise go to ACCESS. From the next cycle, registered outputs are driven:
  - mem_en=1, mem_we=MemWrite&IorD, mem_addr, mem_be, mem_wdata.
  - mem_be:
    - word: 1111.
    - half: 0011 if a[1]=0, else 1100.
    - byte: 0001<<a[1:0].
    - read: same mask as for a write.
  - mem_wdata:
    - byte: {4{wdata[7:0]}}.
    - half: {2{wdata[15:0]}}.
    - word: wdata.
- ACCESS, mem_ready=1 at edge:
  - Fetch: ir<=mem_rdata.
  - Load: mdr<=extended lane data.
    - byte: lane a[1:0].
    - half: lane a[1].
    - word: full.
    - Sign- or zero-extend per dmEXTop.
  - Store: ir and mdr unchanged.
  - Next cycle: done=1, mem_en=0, mem_we=0, mem_be=0, state IDLE.
- Latency: req at edge T, mem_en high from T+1. With mem_ready tied high, capture at T+2 edge and done high during cycle after T+2.
- ACCESS timeout: counter increments each cycle without mem_ready. At count==TIMEOUT:
  - Abort, no capture, done=1 and timeout_err=1, return to IDLE.
  - Counter clears on entry to ACCESS.
- req while busy=1: ignored (no queue, no error).
- req on the same cycle done is high: accepted (back-to-back allowed).
- busy=1 exactly while state==ACCESS.
- done and error pulses are exactly one cycle wide.

Test Plan:
1. Fetch, zero-wait memory:
   - Stimulus: req, IorD=0, pc=0x00400004, mem_rdata=0x8C220008.
   - Required: mem_addr=0x00400004, mem_be=1111, mem_we=0; ir=0x8C220008; done 2 cycles after req.
2. Load byte signed, 3 wait states:
   - Stimulus: alu_out=0x1003, lsop=10, dmEXTop=0, mem_rdata=0x80FF7F01.
   - Required: mem_be=1000; mdr=0xFFFFFF80; busy 4 cycles.
   - Repeat with dmEXTop=1: mdr=0x00000080.
3. Store half:
   - Stimulus: alu_out=0x2002, wdata=0x1234ABCD, MemWrite=1, lsop=01.
   - Required: mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD; mdr unchanged.
4. Misaligned word load:
   - Stimulus: alu_out=0x3001, lsop=00.
   - Required: mem_en never asserts; done and misalign_err high one cycle; mdr unchanged.
5. Timeout:
   - Stimulus: TIMEOUT=4, mem_ready held 0.
   - Required: done and timeout_err after 4 ACCESS cycles; busy drops; ir unchanged.
6. Reset and busy behaviour:
   - Stimulus: assert rst in 2nd wait cycle of a load.
   - Required: mem_en=0 next cycle; all outputs 0; a later mem_ready is ignored.
   - Stimulus: req during busy.
   - Required: no second transaction.
